// File: rtl/mem_arbiter.sv
// Single-port MIX core memory arbiter. The CPU has fixed priority over three
// device channels. The channels are served round-robin among themselves. A
// per-channel wait counter lets a starving channel pre-empt the CPU for one
// cycle. Grants are combinational. Read data returns one cycle after grant.
module mem_arbiter #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 31,
    parameter int unsigned MAXWAIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic            cpu_gnt,
    output logic            cpu_rvalid,
    output logic            cpu_stall,
    input  logic [2:0]      ch_req,
    input  logic [2:0]      ch_we,
    input  logic [3*AW-1:0] ch_addr,
    input  logic [3*DW-1:0] ch_wdata,
    output logic [2:0]      ch_gnt,
    output logic [2:0]      ch_rvalid,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam logic [7:0] MaxWait = 8'(MAXWAIT);

    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] wait_cnt_q [3];
    logic [7:0] wait_cnt_d [3];
    logic       rd_cpu_q;
    logic [2:0] rd_ch_q;
    logic [2:0] urgent;

    // First set bit of mask, scanning from (ptr+1) mod 3 upward with wrap.
    function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            idx = 2'((int'(ptr) + 1 + k) % 3);
            if (mask[idx] && (res == 3'b000)) begin
                res[idx] = 1'b1;
            end
        end
        return res;
    endfunction

    // Urgency: a channel still requesting after MAXWAIT waited cycles.
    always_comb begin
        urgent = '0;
        for (int i = 0; i < 3; i++) begin
            urgent[i] = ch_req[i] && (wait_cnt_q[i] == MaxWait);
        end
    end

    // Grant selection: urgent channels, then CPU, then ordinary channels.
    always_comb begin
        cpu_gnt = 1'b0;
        ch_gnt  = '0;
        if (!reset) begin
            if (|urgent) begin
                ch_gnt = rr_pick(urgent, rr_ptr_q);
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else begin
                ch_gnt = rr_pick(ch_req, rr_ptr_q);
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Memory port mux; an idle cycle still presents the CPU address.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end
        for (int i = 0; i < 3; i++) begin
            if (ch_gnt[i]) begin
                mem_addr  = ch_addr[i*AW +: AW];
                mem_we    = ch_we[i];
                mem_wdata = ch_wdata[i*DW +: DW];
            end
        end
    end

    // Next round-robin pointer: follows the last channel granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        unique case (ch_gnt)
            3'b001:  rr_ptr_d = 2'd0;
            3'b010:  rr_ptr_d = 2'd1;
            3'b100:  rr_ptr_d = 2'd2;
            default: rr_ptr_d = rr_ptr_q;
        endcase
    end

    // Next wait counts: cleared on grant or withdrawal, else saturating count.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (ch_gnt[i] || !ch_req[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] != MaxWait) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 8'd1;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= 2'd2;
            for (int i = 0; i < 3; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < 3; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    // Read-return tracking: remember which requester was granted a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cpu_q <= 1'b0;
            rd_ch_q  <= '0;
        end else begin
            rd_cpu_q <= cpu_gnt & ~cpu_we;
            rd_ch_q  <= ch_gnt & ~ch_we;
        end
    end

    // Gating with reset kills a read granted in the cycle before reset.
    assign cpu_rvalid = rd_cpu_q & ~reset;
    assign ch_rvalid  = rd_ch_q & {3{~reset}};
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks check grants inline,
// and a scoreboard matches every expected read return against rvalid/rdata.
module tb_mem_arbiter;

    localparam int AW      = 12;
    localparam int DW      = 31;
    localparam int MAXWAIT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_req, cpu_we;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic            cpu_gnt, cpu_rvalid, cpu_stall;
    logic [2:0]      ch_req, ch_we;
    logic [3*AW-1:0] ch_addr;
    logic [3*DW-1:0] ch_wdata;
    logic [2:0]      ch_gnt, ch_rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            who;   // 0..2 channel, 3 CPU
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] model [4096];
    logic [DW-1:0] env_mem [4096];
    bit            env_wr [4096];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        if (a == 12'h0FF) return 31'h1234_5678;
        return {a[6:0], a, ~a};
    endfunction

    // Synchronous-read memory seen by the DUT.
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
            env_wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : pattern(mem_addr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each cycle either the due read returns, or no rvalid at all.
    always @(negedge clk) begin
        logic [3:0] exp_rv;
        exp_rv = 4'b0000;
        checks++;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            exp_rv = (sb[0].who == 3) ? 4'b1000 : (4'b0001 << sb[0].who);
            if ({cpu_rvalid, ch_rvalid} !== exp_rv || rdata !== sb[0].data) begin
                failures++;
                $display("FAIL read_return cycle %0d: rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                         cyc, {cpu_rvalid, ch_rvalid}, rdata, exp_rv, sb[0].data);
            end
            void'(sb.pop_front());
        end else if ({cpu_rvalid, ch_rvalid} !== exp_rv) begin
            failures++;
            $display("FAIL spurious_rvalid cycle %0d: rvalid=%b want 0000",
                     cyc, {cpu_rvalid, ch_rvalid});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    endtask

    task automatic push_read(input int who, input logic [AW-1:0] a);
        exp_t e;
        e.who = who; e.data = model[a]; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1;
        cpu_req = 1; cpu_we = 1; ch_req = 3'b111; ch_we = 3'b111;
        cpu_wdata = 31'h5555_5555;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ch_gnt} !== 4'b0000 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b mem_we=%b want gnt=0000 mem_we=0",
                     {cpu_gnt, ch_gnt}, mem_we);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        reset = 0;
        next_cycle();
    endtask

    task automatic test_idle();
        cpu_addr = 12'h123;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ch_gnt} !== 4'b0000 || mem_we !== 1'b0 || mem_addr !== 12'h123 ||
            mem_wdata !== '0) begin
            failures++;
            $display("FAIL idle_port: gnt=%b we=%b addr=%h wdata=%h want 0000 0 123 0",
                     {cpu_gnt, ch_gnt}, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h0FF;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || ch_gnt !== 3'b000 || cpu_stall !== 1'b0 ||
            mem_addr !== 12'h0FF || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_grant: gnt=%b stall=%b addr=%h we=%b want 1000 0 0ff 0",
                     {cpu_gnt, ch_gnt}, cpu_stall, mem_addr, mem_we);
        end
        push_read(3, 12'h0FF);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        ch_addr = {12'h300, 12'h200, 12'h100};
        ch_req  = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            @(negedge clk);
            checks++;
            if (ch_gnt !== exp_g || cpu_gnt !== 1'b0 ||
                mem_addr !== ch_addr[(k % 3)*AW +: AW]) begin
                failures++;
                $display("FAIL rr_order k=%0d: ch_gnt=%b addr=%h want %b",
                         k, ch_gnt, mem_addr, exp_g);
            end
            push_read(k % 3, ch_addr[(k % 3)*AW +: AW]);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_starvation();
        logic ch_turn;
        cpu_req = 1; cpu_addr = 12'h040;
        ch_req  = 3'b010; ch_addr = {12'h0, 12'h222, 12'h0};
        for (int k = 0; k < 18; k++) begin
            ch_turn = (k == MAXWAIT) || (k == 2 * MAXWAIT + 1);
            @(negedge clk);
            checks++;
            if (cpu_gnt !== !ch_turn || ch_gnt !== (ch_turn ? 3'b010 : 3'b000) ||
                cpu_stall !== ch_turn) begin
                failures++;
                $display("FAIL starvation k=%0d: cpu_gnt=%b ch_gnt=%b stall=%b want ch_turn=%b",
                         k, cpu_gnt, ch_gnt, cpu_stall, ch_turn);
            end
            if (ch_turn) push_read(1, 12'h222);
            else         push_read(3, 12'h040);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_write_then_read();
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'hFFF; cpu_wdata = 31'h7FFF_FFFF;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'hFFF ||
            mem_wdata !== 31'h7FFF_FFFF) begin
            failures++;
            $display("FAIL cpu_write: gnt=%b we=%b addr=%h wdata=%h want 1 1 fff 7fffffff",
                     cpu_gnt, mem_we, mem_addr, mem_wdata);
        end
        model[12'hFFF] = 31'h7FFF_FFFF;
        next_cycle();
        idle_inputs();
        ch_req = 3'b100; ch_addr = {12'hFFF, 12'h0, 12'h0};
        @(negedge clk);
        checks++;
        if (ch_gnt !== 3'b100 || mem_we !== 1'b0 || mem_addr !== 12'hFFF) begin
            failures++;
            $display("FAIL ch2_read_grant: ch_gnt=%b we=%b addr=%h want 100 0 fff",
                     ch_gnt, mem_we, mem_addr);
        end
        push_read(2, 12'hFFF);
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        ch_req = 3'b001; ch_addr = {12'h0, 12'h0, 12'h010};
        @(negedge clk);
        checks++;
        if (ch_gnt !== 3'b001) begin
            failures++;
            $display("FAIL pre_reset_grant: ch_gnt=%b want 001", ch_gnt);
        end
        next_cycle();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        checks++;
        if (ch_rvalid !== 3'b000) begin
            failures++;
            $display("FAIL reset_kills_read: ch_rvalid=%b want 000", ch_rvalid);
        end
        next_cycle();
        reset = 0;
        ch_req = 3'b111; ch_addr = {12'h300, 12'h200, 12'h100};
        @(negedge clk);
        checks++;
        if (ch_gnt !== 3'b001) begin
            failures++;
            $display("FAIL rr_after_reset: ch_gnt=%b want 001", ch_gnt);
        end
        push_read(0, 12'h100);
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_withdraw();
        cpu_req = 1; cpu_addr = 12'h050;
        ch_addr = {12'h333, 12'h0, 12'h0};
        // 5 cycles waiting, 1 withdrawn, then a fresh request for MAXWAIT+1 cycles.
        for (int k = 0; k < 15; k++) begin
            logic exp_ch;
            ch_req = (k == 5) ? 3'b000 : 3'b100;
            exp_ch = (k == 6 + MAXWAIT);
            @(negedge clk);
            checks++;
            if (cpu_gnt !== !exp_ch || ch_gnt !== (exp_ch ? 3'b100 : 3'b000)) begin
                failures++;
                $display("FAIL withdraw k=%0d: cpu_gnt=%b ch_gnt=%b want ch2=%b",
                         k, cpu_gnt, ch_gnt, exp_ch);
            end
            if (exp_ch) push_read(2, 12'h333);
            else        push_read(3, 12'h050);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model[i] = pattern(12'(i));
        idle_inputs();
        reset = 1;
        next_cycle();
        test_reset();
        test_idle();
        test_cpu_read();
        test_round_robin();
        test_starvation();
        test_write_then_read();
        test_reset_mid_read();
        test_withdraw();
        next_cycle();
        next_cycle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
